// File: rtl/wwvb_pkg.sv
// Shared definitions for the WWVB transmitter: register map, bit positions,
// marker layout and symbol timing fractions.
package wwvb_pkg;

    localparam logic [2:0] ADDR_CTRL   = 3'd0;
    localparam logic [2:0] ADDR_STATUS = 3'd1;
    localparam logic [2:0] ADDR_AM_LO  = 3'd2;
    localparam logic [2:0] ADDR_AM_HI  = 3'd3;
    localparam logic [2:0] ADDR_PM_LO  = 3'd4;
    localparam logic [2:0] ADDR_PM_HI  = 3'd5;
    localparam logic [2:0] ADDR_COMMIT = 3'd6;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_PM_EN   = 1;
    localparam int CTRL_IRQ_EN  = 2;

    localparam int STAT_PENDING  = 0;
    localparam int STAT_UNDERRUN = 1;
    localparam int STAT_SOF      = 2;
    localparam int STAT_SEC_LSB  = 8;

    localparam int FRAME_SECS = 60;

    // Seconds that always carry a position marker, whatever the AM bit says
    localparam logic [59:0] MARKER_MASK = (60'd1 << 0)  | (60'd1 << 9)  | (60'd1 << 19) |
                                          (60'd1 << 29) | (60'd1 << 39) | (60'd1 << 49) |
                                          (60'd1 << 59);

    // Reduced-power portion of a second as a fraction of the second
    localparam int LOW0_NUM = 1;
    localparam int LOW0_DEN = 5;
    localparam int LOW1_NUM = 1;
    localparam int LOW1_DEN = 2;
    localparam int LOWM_NUM = 4;
    localparam int LOWM_DEN = 5;

    typedef enum logic [1:0] {
        SYM0,
        SYM1,
        SYM_MARK
    } symbol_t;

    function automatic symbol_t symbol_of(input logic is_marker, input logic am_bit);
        if (is_marker) return SYM_MARK;
        return am_bit ? SYM1 : SYM0;
    endfunction

endpackage

// File: rtl/wwvb_nco.sv
// Phase-accumulator carrier generator; the square-wave output is the
// accumulator MSB. clear holds the phase at zero.
module wwvb_nco #(
    parameter int               ACC_W = 32,
    parameter logic [ACC_W-1:0] INC   = '0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    output logic carrier
);

    logic [ACC_W-1:0] acc_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_reg <= '0;
        end else if (clear) begin
            acc_reg <= '0;
        end else begin
            acc_reg <= acc_reg + INC;
        end
    end

    assign carrier = acc_reg[ACC_W-1];

endmodule

// File: rtl/wwvb_frame_tx.sv
// WWVB time-code transmitter: Avalon-MM register file, double-buffered
// 60-second frame and the per-second AM/PM symbol sequencer.
module wwvb_frame_tx
    import wwvb_pkg::*;
#(
    parameter int CLOCK_FREQ     = 100_000_000,
    parameter int CARRIER_FREQ   = 60_000,
    parameter int CYCLES_PER_SEC = CLOCK_FREQ,
    parameter int ACC_W          = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        write,
    input  logic        read,
    input  logic [3:0]  byteenable,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        wwvb,
    output logic        wwvb_reduced,
    output logic        pps,
    output logic        irq
);

    localparam int TW = $clog2(CYCLES_PER_SEC + 1);
    localparam logic [63:0] INC_WIDE =
        ((64'(CARRIER_FREQ) << ACC_W) + 64'(CLOCK_FREQ / 2)) / 64'(CLOCK_FREQ);
    localparam logic [ACC_W-1:0] INC = INC_WIDE[ACC_W-1:0];

    localparam logic [TW-1:0] TIMER_LAST = TW'(CYCLES_PER_SEC - 1);
    localparam logic [TW-1:0] LOW_SYM0   = TW'(CYCLES_PER_SEC * LOW0_NUM / LOW0_DEN);
    localparam logic [TW-1:0] LOW_SYM1   = TW'(CYCLES_PER_SEC * LOW1_NUM / LOW1_DEN);
    localparam logic [TW-1:0] LOW_MARK   = TW'(CYCLES_PER_SEC * LOWM_NUM / LOWM_DEN);
    localparam logic [5:0]    SEC_LAST   = 6'(FRAME_SECS - 1);

    logic [2:0]    ctrl_reg, ctrl_next;
    logic          pending_reg, pending_next;
    logic          underrun_reg, underrun_next;
    logic          sof_reg, sof_next;
    logic [59:0]   shadow_am_reg, shadow_am_next;
    logic [59:0]   shadow_pm_reg, shadow_pm_next;
    logic [59:0]   active_am_reg, active_am_next;
    logic [59:0]   active_pm_reg, active_pm_next;
    logic [TW-1:0] timer_reg, timer_next;
    logic [5:0]    sec_reg, sec_next;
    logic [31:0]   readdata_next;

    logic [31:0]   be_mask;
    logic [31:0]   rd_word;
    logic [31:0]   wr_merged;
    logic          en_now;
    logic          en_next;
    logic          frame_start;
    logic          carrier;
    symbol_t       sym;
    logic [TW-1:0] low_len;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_be
            assign be_mask[gi*8 +: 8] = {8{byteenable[gi]}};
        end
    endgenerate

    assign en_now = ctrl_reg[CTRL_EN];

    // The addressed register's current value doubles as the merge base for byte-lane writes
    always_comb begin
        rd_word = '0;
        case (address)
            ADDR_CTRL:   rd_word = {29'd0, ctrl_reg};
            ADDR_STATUS: rd_word = {18'd0, sec_reg, 5'd0, sof_reg, underrun_reg, pending_reg};
            ADDR_AM_LO:  rd_word = shadow_am_reg[31:0];
            ADDR_AM_HI:  rd_word = {4'd0, shadow_am_reg[59:32]};
            ADDR_PM_LO:  rd_word = shadow_pm_reg[31:0];
            ADDR_PM_HI:  rd_word = {4'd0, shadow_pm_reg[59:32]};
            default:     rd_word = '0;
        endcase
    end

    assign wr_merged     = (rd_word & ~be_mask) | (writedata & be_mask);
    assign readdata_next = read ? rd_word : 32'd0;

    always_comb begin
        ctrl_next      = ctrl_reg;
        pending_next   = pending_reg;
        underrun_next  = underrun_reg;
        sof_next       = sof_reg;
        shadow_am_next = shadow_am_reg;
        shadow_pm_next = shadow_pm_reg;
        active_am_next = active_am_reg;
        active_pm_next = active_pm_reg;
        timer_next     = '0;
        sec_next       = '0;
        frame_start    = 1'b0;
        en_next        = 1'b0;

        if (write) begin
            case (address)
                ADDR_CTRL:   ctrl_next = wr_merged[2:0];
                ADDR_STATUS: begin
                    if (writedata[STAT_UNDERRUN]) underrun_next = 1'b0;
                    if (writedata[STAT_SOF])      sof_next      = 1'b0;
                end
                ADDR_AM_LO:  shadow_am_next[31:0]  = wr_merged;
                ADDR_AM_HI:  shadow_am_next[59:32] = wr_merged[27:0];
                ADDR_PM_LO:  shadow_pm_next[31:0]  = wr_merged;
                ADDR_PM_HI:  shadow_pm_next[59:32] = wr_merged[27:0];
                default: ;
            endcase
        end

        en_next = ctrl_next[CTRL_EN];
        // A frame starts on enable or after the last cycle of second 59
        frame_start = en_next &&
                      (!en_now || (timer_reg == TIMER_LAST && sec_reg == SEC_LAST));

        if (frame_start) begin
            sof_next = 1'b1;
            if (pending_reg) begin
                active_am_next = shadow_am_reg;
                active_pm_next = shadow_pm_reg;
                pending_next   = 1'b0;
            end else begin
                underrun_next  = 1'b1;
            end
        end
        if (write && address == ADDR_COMMIT) pending_next = 1'b1;

        if (en_now && en_next) begin
            if (timer_reg == TIMER_LAST) begin
                timer_next = '0;
                sec_next   = (sec_reg == SEC_LAST) ? 6'd0 : sec_reg + 6'd1;
            end else begin
                timer_next = timer_reg + TW'(1);
                sec_next   = sec_reg;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_reg      <= '0;
            pending_reg   <= 1'b0;
            underrun_reg  <= 1'b0;
            sof_reg       <= 1'b0;
            shadow_am_reg <= '0;
            shadow_pm_reg <= '0;
            active_am_reg <= '0;
            active_pm_reg <= '0;
            timer_reg     <= '0;
            sec_reg       <= '0;
            readdata      <= '0;
        end else begin
            ctrl_reg      <= ctrl_next;
            pending_reg   <= pending_next;
            underrun_reg  <= underrun_next;
            sof_reg       <= sof_next;
            shadow_am_reg <= shadow_am_next;
            shadow_pm_reg <= shadow_pm_next;
            active_am_reg <= active_am_next;
            active_pm_reg <= active_pm_next;
            timer_reg     <= timer_next;
            sec_reg       <= sec_next;
            readdata      <= readdata_next;
        end
    end

    wwvb_nco #(
        .ACC_W (ACC_W),
        .INC   (INC)
    ) u_nco (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (!en_now),
        .carrier (carrier)
    );

    assign sym = symbol_of(MARKER_MASK[sec_reg], active_am_reg[sec_reg]);

    always_comb begin
        case (sym)
            SYM0:    low_len = LOW_SYM0;
            SYM1:    low_len = LOW_SYM1;
            default: low_len = LOW_MARK;
        endcase
    end

    assign wwvb_reduced = en_now && (timer_reg < low_len);
    assign pps          = en_now && (timer_reg == '0);
    assign wwvb         = en_now && (carrier ^ (ctrl_reg[CTRL_PM_EN] && active_pm_reg[sec_reg]));
    assign irq          = sof_reg && ctrl_reg[CTRL_IRQ_EN];

endmodule

// File: tb/tb_wwvb_frame_tx.sv
// Self-checking bench for wwvb_frame_tx with a 100-cycle second and a
// 10-cycle carrier period; register reads and per-second symbols are scoreboarded.
module tb_wwvb_frame_tx;

    localparam logic [2:0] A_CTRL   = 3'd0;
    localparam logic [2:0] A_STATUS = 3'd1;
    localparam logic [2:0] A_AM_LO  = 3'd2;
    localparam logic [2:0] A_AM_HI  = 3'd3;
    localparam logic [2:0] A_PM_HI  = 3'd5;
    localparam logic [2:0] A_PM_LO  = 3'd4;
    localparam logic [2:0] A_COMMIT = 3'd6;
    localparam logic [2:0] A_NONE   = 3'd7;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        write;
    logic        read;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        wwvb;
    logic        wwvb_reduced;
    logic        pps;
    logic        irq;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int unsigned t0 = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];
    int          red_q[$];
    int          inv_q[$];

    wwvb_frame_tx #(
        .CLOCK_FREQ     (1000),
        .CARRIER_FREQ   (100),
        .CYCLES_PER_SEC (100),
        .ACC_W          (32)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .address      (address),
        .write        (write),
        .read         (read),
        .byteenable   (byteenable),
        .writedata    (writedata),
        .readdata     (readdata),
        .wwvb         (wwvb),
        .wwvb_reduced (wwvb_reduced),
        .pps          (pps),
        .irq          (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        address    = a;
        writedata  = d;
        byteenable = be;
        write      = 1'b1;
        @(negedge clk);
        write      = 1'b0;
        byteenable = 4'h0;
        $display("wr   addr=%0d data=0x%08h be=0x%h", a, d, be);
    endtask

    task automatic bus_read(input logic [2:0] a, input logic [31:0] exp, input string tag);
        @(negedge clk);
        address = a;
        read    = 1'b1;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(negedge clk);
        read = 1'b0;
        check(tag_q.pop_front(), readdata, exp_q.pop_front());
    endtask

    task automatic push_sec(input int red, input int inv);
        red_q.push_back(red);
        inv_q.push_back(inv);
    endtask

    // Measures one whole second starting at the next pps: reduced-cycle count and
    // number of cycles where wwvb differs from an unmodulated 10-cycle square wave.
    task automatic measure_sec(input string tag);
        int waited = 0;
        int red = 0;
        int inv = 0;
        int unsigned n;
        logic ref_c;
        while (pps !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_sync"}, 32'(pps), 32'd1);
        for (int i = 0; i < 100; i++) begin
            n = cyc - t0;
            ref_c = ((n / 5) % 2) == 1;
            if (wwvb_reduced === 1'b1) red++;
            if (wwvb !== ref_c) inv++;
            @(negedge clk);
        end
        if (red_q.size() == 0) begin
            check({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            check({tag, "_low"}, red, red_q.pop_front());
            check({tag, "_pm"}, inv, inv_q.pop_front());
        end
    endtask

    task automatic wait_irq(input string tag);
        int waited = 0;
        while (irq !== 1'b1 && waited < 7000) begin
            @(negedge clk);
            waited++;
        end
        check(tag, 32'(irq), 32'd1);
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = '0;
        write      = 1'b0;
        read       = 1'b0;
        byteenable = '0;
        writedata  = '0;
        repeat (3) @(negedge clk);
        check("rst_wwvb", 32'(wwvb), 32'd0);
        check("rst_reduced", 32'(wwvb_reduced), 32'd0);
        check("rst_pps", 32'(pps), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_readdata", readdata, 32'd0);
        reset_n = 1'b1;
        for (int a = 0; a < 8; a++) bus_read(3'(a), 32'd0, $sformatf("rst_reg%0d", a));

        // Frame 1: sec1 carries a one, sec2 is phase-modulated
        bus_write(A_AM_LO, 32'h2, 4'hF);
        bus_write(A_PM_LO, 32'h4, 4'hF);
        bus_write(A_COMMIT, 32'h0, 4'hF);
        bus_read(A_STATUS, 32'h1, "commit_pending");
        for (int s = 0; s < 10; s++)
            push_sec((s == 0 || s == 9) ? 80 : (s == 1) ? 50 : 20, (s == 2) ? 100 : 0);
        bus_write(A_CTRL, 32'h3, 4'hF);
        check("en_first_pps", 32'(pps), 32'd1);
        t0 = cyc;
        for (int s = 0; s < 10; s++) measure_sec($sformatf("f1_s%0d", s));
        bus_read(A_STATUS, 32'h0000_0A04, "f1_status");
        check("f1_irq_off", 32'(irq), 32'd0);

        // Frame 2: no commit, so the frame repeats and UNDERRUN is flagged
        bus_write(A_CTRL, 32'h5, 4'hF);
        bus_write(A_STATUS, 32'h4, 4'hF);
        check("sof_w1c_irq", 32'(irq), 32'd0);
        wait_irq("f2_irq");
        bus_read(A_STATUS, 32'h6, "f2_status_underrun");
        bus_write(A_STATUS, 32'h6, 4'hF);
        bus_read(A_STATUS, 32'h0, "f2_status_cleared");
        check("f2_irq_cleared", 32'(irq), 32'd0);
        bus_write(A_AM_LO, 32'h8, 4'hF);
        push_sec(50, 0);
        push_sec(20, 0);
        measure_sec("f2_s1");
        measure_sec("f2_s2");

        // Commit exactly on the frame-boundary edge: now at sec3 cycle 0
        repeat (5698) @(negedge clk);
        bus_write(A_COMMIT, 32'h0, 4'hF);
        check("f3_boundary_pps", 32'(pps), 32'd1);
        bus_read(A_STATUS, 32'h7, "f3_commit_on_boundary");
        push_sec(50, 0);
        push_sec(20, 0);
        push_sec(20, 0);
        for (int s = 1; s < 4; s++) measure_sec($sformatf("f3_s%0d", s));

        // Frame 4 uses the frame committed on the boundary
        bus_write(A_STATUS, 32'h4, 4'hF);
        wait_irq("f4_irq");
        push_sec(80, 0);
        push_sec(20, 0);
        push_sec(20, 0);
        push_sec(50, 0);
        for (int s = 0; s < 4; s++) measure_sec($sformatf("f4_s%0d", s));

        // Drop EN in the middle of second 30
        repeat (2605) @(negedge clk);
        check("s30_reduced_before", 32'(wwvb_reduced), 32'd1);
        bus_write(A_CTRL, 32'h4, 4'h1);
        check("dis_reduced", 32'(wwvb_reduced), 32'd0);
        check("dis_pps", 32'(pps), 32'd0);
        begin
            int hi = 0;
            for (int i = 0; i < 20; i++) begin
                if (wwvb !== 1'b0) hi++;
                @(negedge clk);
            end
            check("dis_wwvb_quiet", hi, 0);
        end
        bus_read(A_STATUS, 32'h6, "dis_status");

        // Byte lanes, masked widths, unused address
        bus_write(A_AM_LO, 32'hFFFF_FFFF, 4'h1);
        bus_read(A_AM_LO, 32'h0000_00FF, "be_am_lo");
        @(negedge clk);
        check("rd_idle_zero", readdata, 32'd0);
        bus_write(A_AM_HI, 32'hFFFF_FFFF, 4'hF);
        bus_read(A_AM_HI, 32'h0FFF_FFFF, "am_hi_width");
        bus_write(A_PM_HI, 32'hFFFF_FFFF, 4'hC);
        bus_read(A_PM_HI, 32'h0FFF_0000, "be_pm_hi");
        bus_write(A_CTRL, 32'hFFFF_FFFF, 4'hE);
        bus_read(A_CTRL, 32'h4, "be_ctrl");
        bus_write(A_NONE, 32'hFFFF_FFFF, 4'hF);
        bus_read(A_NONE, 32'h0, "addr7");

        // Asynchronous reset while running
        bus_write(A_CTRL, 32'h5, 4'hF);
        check("re_en_pps", 32'(pps), 32'd1);
        repeat (7) @(negedge clk);
        check("pre_rst_reduced", 32'(wwvb_reduced), 32'd1);
        check("pre_rst_irq", 32'(irq), 32'd1);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("arst_reduced", 32'(wwvb_reduced), 32'd0);
        check("arst_wwvb", 32'(wwvb), 32'd0);
        check("arst_irq", 32'(irq), 32'd0);
        check("arst_readdata", readdata, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        bus_read(A_CTRL, 32'h0, "arst_ctrl");
        bus_read(A_STATUS, 32'h0, "arst_status");
        bus_read(A_AM_LO, 32'h0, "arst_am_lo");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
